// File: rtl/store_buffer.sv
// Store buffer: holds stores from issue-time allocation through ROB commit until
// they are written to data memory, with load-address hazard tracking per entry.
module store_buffer #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned SB_INDEX_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [SB_INDEX_WIDTH-1:0] alloc_index,
    input  logic                      exec_valid,
    input  logic [SB_INDEX_WIDTH-1:0] exec_index,
    input  logic [XLEN-1:0]           exec_address,
    input  logic [XLEN-1:0]           exec_data,
    input  logic [3:0]                exec_byte_en,
    input  logic                      load_issue_valid,
    input  logic [XLEN-1:0]           load_issue_address,
    input  logic                      store_commit_valid,
    output logic                      store_commit_ready,
    output logic                      store_commit_hazard,
    output logic                      mem_write_valid,
    input  logic                      mem_write_ready,
    output logic [XLEN-1:0]           mem_write_address,
    output logic [XLEN-1:0]           mem_write_data,
    output logic [3:0]                mem_write_byte_en,
    input  logic                      flush,
    output logic                      empty
);

    localparam int unsigned DEPTH = 1 << SB_INDEX_WIDTH;
    localparam logic [SB_INDEX_WIDTH-1:0] IDX_ONE   = SB_INDEX_WIDTH'(1);
    localparam logic [SB_INDEX_WIDTH:0]   CNT_ONE   = (SB_INDEX_WIDTH + 1)'(1);
    localparam logic [SB_INDEX_WIDTH:0]   CNT_DEPTH = (SB_INDEX_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_FREE,
        S_ALLOC,
        S_READY,
        S_COMMITTED
    } entry_state_t;

    entry_state_t              r_state [DEPTH];
    logic                      r_hazard[DEPTH];
    logic [XLEN-1:0]           r_addr  [DEPTH];
    logic [XLEN-1:0]           r_data  [DEPTH];
    logic [3:0]                r_be    [DEPTH];
    logic [SB_INDEX_WIDTH-1:0] r_head;
    logic [SB_INDEX_WIDTH-1:0] r_cptr;
    logic [SB_INDEX_WIDTH-1:0] r_tail;
    logic [SB_INDEX_WIDTH:0]   r_count;

    logic                      w_alloc_ready;
    logic                      w_commit_ready;
    logic                      w_mem_valid;
    logic                      w_alloc;
    logic                      w_exec;
    logic                      w_commit;
    logic                      w_drain;
    logic [SB_INDEX_WIDTH-1:0] w_cptr_next;
    logic [SB_INDEX_WIDTH:0]   w_flush_cnt;
    logic [SB_INDEX_WIDTH:0]   w_count_next;
    logic                      w_unused_load_lsb;

    // Hazard matching is word-granular, so the byte offset of the load is irrelevant.
    assign w_unused_load_lsb = &{1'b0, load_issue_address[1:0]};

    always_comb begin
        w_alloc_ready  = (r_count != CNT_DEPTH);
        w_commit_ready = (r_state[r_cptr] == S_READY);
        w_mem_valid    = (r_state[r_head] == S_COMMITTED);
        w_alloc        = alloc_valid && w_alloc_ready && !flush;
        w_exec         = exec_valid && !flush && (r_state[exec_index] == S_ALLOC);
        w_commit       = store_commit_valid && w_commit_ready;
        w_drain        = w_mem_valid && mem_write_ready;
        w_cptr_next    = w_commit ? (r_cptr + IDX_ONE) : r_cptr;
    end

    // Entries discarded by a flush: every uncommitted one except a store committing this cycle.
    always_comb begin
        w_flush_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((r_state[i] == S_ALLOC || r_state[i] == S_READY) &&
                !(w_commit && r_cptr == SB_INDEX_WIDTH'(i))) begin
                w_flush_cnt = w_flush_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_alloc) w_count_next = w_count_next + CNT_ONE;
        if (w_drain) w_count_next = w_count_next - CNT_ONE;
        if (flush)   w_count_next = w_count_next - w_flush_cnt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_state[i]  <= S_FREE;
                r_hazard[i] <= 1'b0;
                r_addr[i]   <= '0;
                r_data[i]   <= '0;
                r_be[i]     <= '0;
            end
            r_head  <= '0;
            r_cptr  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                // Snoop sees pre-update state, so an entry executed this cycle still counts as ALLOC.
                if (load_issue_valid &&
                    (r_state[i] == S_ALLOC ||
                     (r_state[i] == S_READY &&
                      r_addr[i][XLEN-1:2] == load_issue_address[XLEN-1:2]))) begin
                    r_hazard[i] <= 1'b1;
                end
                case (r_state[i])
                    S_FREE: begin
                        if (w_alloc && r_tail == SB_INDEX_WIDTH'(i)) begin
                            r_state[i]  <= S_ALLOC;
                            r_hazard[i] <= 1'b0;
                        end
                    end
                    S_ALLOC: begin
                        if (flush) begin
                            r_state[i] <= S_FREE;
                        end else if (w_exec && exec_index == SB_INDEX_WIDTH'(i)) begin
                            r_state[i] <= S_READY;
                        end
                    end
                    S_READY: begin
                        if (w_commit && r_cptr == SB_INDEX_WIDTH'(i)) begin
                            r_state[i] <= S_COMMITTED;
                        end else if (flush) begin
                            r_state[i] <= S_FREE;
                        end
                    end
                    S_COMMITTED: begin
                        if (w_drain && r_head == SB_INDEX_WIDTH'(i)) begin
                            r_state[i] <= S_FREE;
                        end
                    end
                    default: r_state[i] <= S_FREE;
                endcase
            end
            if (w_exec) begin
                r_addr[exec_index] <= exec_address;
                r_data[exec_index] <= exec_data;
                r_be[exec_index]   <= exec_byte_en;
            end
            if (w_drain) r_head <= r_head + IDX_ONE;
            r_cptr <= w_cptr_next;
            if (flush) begin
                r_tail <= w_cptr_next;
            end else if (w_alloc) begin
                r_tail <= r_tail + IDX_ONE;
            end
            r_count <= w_count_next;
        end
    end

    assign alloc_ready         = w_alloc_ready;
    assign alloc_index         = r_tail;
    assign store_commit_ready  = w_commit_ready;
    assign store_commit_hazard = w_commit_ready && r_hazard[r_cptr];
    assign mem_write_valid     = w_mem_valid;
    assign mem_write_address   = r_addr[r_head];
    assign mem_write_data      = r_data[r_head];
    assign mem_write_byte_en   = r_be[r_head];
    assign empty               = (r_count == '0);

endmodule

// File: doc/store_buffer.md
# store_buffer

Holds issued stores from allocation until they are written to data memory. The block sits directly downstream of `reorder_buffer` on the store commit port. Each store follows the same path: it is allocated in program order at issue, receives its address and data from the execute lanes, and is committed by the ROB in order. It is then drained to memory. Speculative, uncommitted stores are discarded on `flush`.

## Interface
- `XLEN`, 32, address/data width
- `SB_INDEX_WIDTH`, 5, entry index bits; depth = 2^SB_INDEX_WIDTH
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `alloc_valid` in 1: issue stage requests a new store entry
- `alloc_ready` out 1: at least one free entry exists
- `alloc_index` out SB_INDEX_WIDTH: entry granted; equals tail pointer
- `exec_valid` in 1: address/data for an entry are ready
- `exec_index` in SB_INDEX_WIDTH: target entry
- `exec_address` in XLEN: store byte address
- `exec_data` in XLEN: store data
- `exec_byte_en` in 4: byte enables
- `load_issue_valid` in 1: a load was sent to memory this cycle
- `load_issue_address` in XLEN: that load's byte address
- `store_commit_valid` in 1: ROB head is a store and is committing
- `store_commit_ready` out 1: entry at the commit pointer holds address and data
- `store_commit_hazard` out 1: the committing store conflicts with an already-issued load
- `mem_write_valid` out 1: head entry is committed and being offered to memory
- `mem_write_ready` in 1: memory accepts the write
- `mem_write_address`, `mem_write_data` out XLEN; `mem_write_byte_en` out 4
- `flush` in 1: discard all uncommitted entries
- `empty` out 1: no entries in use

## Operation
- Per-entry state is one of FREE, ALLOC, READY or COMMITTED, plus a hazard bit, address, data and byte enables.
- The block keeps three pointers plus an occupancy count:
  - `head`: oldest entry, next to drain.
  - `cptr`: next entry to commit.
  - `tail`: next entry to allocate.
  - The occupancy count is SB_INDEX_WIDTH+1 bits. All pointers wrap modulo the depth.
- **Allocate:** on `alloc_valid & alloc_ready`, entry[tail] goes FREE→ALLOC, its hazard bit is cleared, and tail increments.
- **Execute:** on `exec_valid`, if entry[exec_index] is ALLOC, it latches address, data and byte enables and goes to READY. If the entry is in any other state, the write is ignored.
- **Load snoop:** on `load_issue_valid`, every entry in ALLOC sets its hazard bit, because its address is unknown. Every entry in READY whose `address[XLEN-1:2]` equals `load_issue_address[XLEN-1:2]` also sets its hazard bit.
- **Commit:**
  - `store_commit_ready` = (entry[cptr] == READY).
  - `store_commit_hazard` = entry[cptr].hazard when `store_commit_ready` is high, otherwise 0.
  - On `store_commit_valid & store_commit_ready`, the entry goes to COMMITTED and cptr increments.
  - If `store_commit_valid` is high while ready is low, the ROB holds it and the block takes no action.
- **Drain:**
  - `mem_write_valid` = (entry[head] == COMMITTED). The `mem_write_*` outputs drive entry[head] fields.
  - On `mem_write_valid & mem_write_ready`, the entry goes FREE and head increments.
- **Flush:** all ALLOC and READY entries go FREE, tail ← cptr, and the count is reduced accordingly. COMMITTED entries keep draining.
- **Simultaneous events in one cycle:**
  - Allocate and drain in the same cycle leave the count unchanged.
  - A commit coinciding with `flush` is honored first, then flush applies with tail ← cptr+1.
  - `alloc_valid` during `flush` is dropped.
  - An execute write during `flush` is dropped.
  - Snoop and execute to the same entry in one cycle: the hazard is evaluated against the pre-write (ALLOC) state, so the hazard bit is set.
- **Full:** `alloc_ready` = 0 when count == depth. There is no same-cycle bypass from a drain.

## Timing
- **Reset (asserted low):**
  - All entries go FREE; head = cptr = tail = 0; count = 0.
  - Outputs: `alloc_ready`=1, `alloc_index`=0, `store_commit_ready`=0, `store_commit_hazard`=0, `mem_write_valid`=0, `mem_write_*`=0, `empty`=1.
  - A reset during operation discards all state, committed entries included.
- `alloc_ready`, `alloc_index`, `store_commit_ready`, `store_commit_hazard`, `mem_write_*` and `empty` are combinational from registered state only. No input feeds them combinationally.
- An entry executed at edge N can commit at edge N+1. An entry committed at edge N can be offered to memory from cycle N+1.
- Hazard bits set by a snoop at edge N are visible on `store_commit_hazard` from cycle N+1.
- `mem_write_valid` stays high, with stable data, until `mem_write_ready` is sampled high.

## Test plan
- **Reset values:** after reset, check `alloc_ready`=1, `empty`=1, `store_commit_ready`=0, `mem_write_valid`=0.
- **In-order path:**
  - Stimulus: allocate 3 stores (indexes 0, 1, 2), then execute them in the order 2, 0, 1 with addresses 0x100, 0x104, 0x108 and data 0xA0, 0xA1, 0xA2.
  - Response: commit ready goes high only once entry 0 is READY. Three commits follow. Memory sees 0x100/0xA0, 0x104/0xA1, 0x108/0xA2 in that order; `empty`=1 afterwards.
- **Full and wrap:**
  - Stimulus: allocate 32 entries with memory stalled.
  - Response: `alloc_ready`=0. After draining one committed entry, allocation resumes at `alloc_index`=0 (wrap-around).
- **Hazard:**
  - Stimulus: allocate entry 0, then issue a load to 0x200. Execute entry 0 to 0x200.
  - Response: commit shows `store_commit_hazard`=1.
  - Stimulus: repeat with the store executed to 0x300 before a load to 0x200.
  - Response: hazard=0.
- **Flush:**
  - Stimulus: allocate 4 entries, commit 2, then assert `flush`.
  - Response: `alloc_index` returns to 2. The 2 committed stores still reach memory; the uncommitted ones never do.
- **Backpressure:**
  - Stimulus: hold `mem_write_ready`=0 for 5 cycles with a committed head.
  - Response: `mem_write_valid` and data stay stable throughout, and exactly one write completes when ready rises.
